// File: rtl/instruction_queue.sv
// Prefetch FIFO of DEPTH instructions feeding a current-instruction register.
// Define IQ_BYPASS_EN to let push+pop on an empty FIFO load the bus word straight into cur.
module instruction_queue #(
  parameter int WIDTH    = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        n_load,
  input  logic                        advance,
  input  logic                        n_enable,
  inout  wire  [WIDTH-1:0]            bus,
  output logic [OPCODE_W-1:0]         opcode,
  output logic                        valid,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);
  localparam int OPERAND_W = WIDTH - OPCODE_W;
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd, wr;
  logic [WIDTH-1:0] cur;
  logic             push, pop, do_push, do_pop, bypass;

  assign push  = !n_load;
  assign pop   = advance;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop on a full FIFO frees the head slot in the same edge, so the push fits.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    bypass  = 1'b0;
`ifdef IQ_BYPASS_EN
    bypass  = push && pop && empty;
    if (bypass) do_push = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) mem[wr] <= bus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      cur      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      cur      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (bypass) begin
        cur   <= bus;
        valid <= 1'b1;
      end else if (pop) begin
        // popping an empty FIFO retires a NOP
        cur   <= do_pop ? mem[rd] : '0;
        valid <= do_pop;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign opcode = cur[WIDTH-1 -: OPCODE_W];

  // Only the operand field is ever driven; opcode bits stay released.
  assign bus[OPERAND_W-1:0] = n_enable ? {OPERAND_W{1'bz}} : cur[OPERAND_W-1:0];

endmodule
